// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, bubble encoding, control opcodes,
// fetch state enum and the fetch per-edge action enum.
// Ports: none (package).
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    // ADD R0,R0,R0: R0 writes are discarded, so this is a harmless bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    localparam logic [3:0] OP_JAL = 4'b1101;
    localparam logic [3:0] OP_JR  = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    // What the fetch stage does on the coming edge, in priority order.
    typedef enum logic [2:0] {
        ACT_BRANCH,
        ACT_STALL,
        ACT_HALT,
        ACT_JUMP,
        ACT_FETCH,
        ACT_FROZEN
    } fetch_act_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port,
// and the IF/ID register contents out to decode.
// master: the fetch stage. slave: its environment (decode/execute/hazard/imem).
interface instr_fetch_if
    import cpu_pkg::*;
#(
    parameter int PC_W_P    = PC_W,
    parameter int INSTR_W_P = INSTR_W
);
    logic                 stall;
    logic                 j_ctrl;
    logic [PC_W_P-1:0]    j_pc;
    logic                 br_ctrl;
    logic [PC_W_P-1:0]    br_pc;
    logic                 hlt;
    logic [PC_W_P-1:0]    im_addr;
    logic [INSTR_W_P-1:0] im_data;
    logic [INSTR_W_P-1:0] instr;
    logic [PC_W_P-1:0]    pc;
    logic                 valid;
    logic                 halted;

    modport master (
        input  stall, j_ctrl, j_pc, br_ctrl, br_pc, hlt, im_data,
        output im_addr, instr, pc, valid, halted
    );

    modport slave (
        output stall, j_ctrl, j_pc, br_ctrl, br_pc, hlt, im_data,
        input  im_addr, instr, pc, valid, halted
    );
endinterface

// File: rtl/if_id_reg.sv
// Generic stage register holding instr/pc/valid.
// Ports: clk, rst_n (async low); load captures d_instr/d_pc with valid=1;
// bubble (wins over load) writes NOP_I/pc=0/valid=0; neither holds.
module if_id_reg #(
    parameter int                 INSTR_W = 16,
    parameter int                 PC_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_I   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_I;
            pc    <= '0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_I;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= d_instr;
            pc    <= d_pc;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives im_addr, applies branch/jump redirects,
// hazard stalls and the halt freeze, and loads the IF/ID register.
// Ports: clk, rst_n (async low), bus (instr_fetch_if.master).
// Build option IF_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt/flush_cnt outputs.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                 PC_W      = cpu_pkg::PC_W,
    parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RST_PC    = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
`ifdef IF_PERF_CNT_EN
    output logic [15:0]    fetch_cnt,
    output logic [15:0]    stall_cnt,
    output logic [15:0]    flush_cnt,
`endif
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);
    fetch_state_e    state, state_nxt;
    fetch_act_e      act;
    logic [PC_W-1:0] pc_q, pc_nxt;
    logic            ld, bub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc_q  <= RST_PC;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
        end
    end

    // j_ctrl/hlt are only trusted when IF/ID (i.e. decode) holds a real
    // instruction; a branch squashes decode, so it outranks them and stall.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ld        = 1'b0;
        bub       = 1'b0;
        act       = ACT_FROZEN;
        if (state == RUN) begin
            if (bus.br_ctrl) begin
                act    = ACT_BRANCH;
                pc_nxt = bus.br_pc;
                bub    = 1'b1;
            end else if (bus.stall) begin
                act = ACT_STALL;
            end else if (bus.valid && bus.hlt) begin
                act       = ACT_HALT;
                state_nxt = HALT;
                bub       = 1'b1;
            end else if (bus.valid && bus.j_ctrl) begin
                act    = ACT_JUMP;
                pc_nxt = bus.j_pc;
                bub    = 1'b1;
            end else begin
                act    = ACT_FETCH;
                ld     = 1'b1;
                pc_nxt = pc_q + PC_W'(1);
            end
        end else begin
            bub = 1'b1;
        end
    end

    assign bus.im_addr = pc_q;
    assign bus.halted  = (state == HALT);

    if_id_reg #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .NOP_I   (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld),
        .bubble  (bub),
        .d_instr (bus.im_data),
        .d_pc    (pc_q),
        .instr   (bus.instr),
        .pc      (bus.pc),
        .valid   (bus.valid)
    );

`ifdef IF_PERF_CNT_EN
    // act is ACT_FROZEN throughout HALT, so the counters freeze there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (act)
                ACT_FETCH:           fetch_cnt <= sat_inc16(fetch_cnt);
                ACT_STALL:           stall_cnt <= sat_inc16(stall_cnt);
                ACT_BRANCH, ACT_JUMP: flush_cnt <= sat_inc16(flush_cnt);
                default: ;
            endcase
        end
    end
`endif
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage plus IF/ID pipeline register; sits directly upstream of the instruction decode stage.
- Owns the PC and drives the instruction-memory address. Latches fetched instruction and its PC into IF/ID.
- Applies redirects: jumps resolved in decode, branches resolved in execute. Also applies hazard stalls and the halt freeze.

Parameters:
- PC_W, 16, PC and instruction-address width.
- INSTR_W, 16, instruction width.
- RST_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding (ADD R0,R0,R0; write to R0 has no effect).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- j_ctrl  input  1  decode has a jal/jr this cycle.
- j_pc  input  16  jump target from decode.
- br_ctrl  input  1  execute resolved a taken branch.
- br_pc  input  16  branch target from execute.
- hlt  input  1  decode holds a hlt instruction.
- im_addr  output  16  instruction-memory address; combinational copy of PC.
- im_data  input  16  instruction-memory read data; combinational, same cycle.
- instr  output  16  IF/ID instruction, to decode.
- pc  output  16  IF/ID address of that instruction, to decode.
- valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- halted  output  1  fetch is frozen in HALT.

Behaviour:
- Reset: asynchronous on rst_n low.
  - PC = RST_PC, instr = NOP_INSTR, pc = 0, valid = 0, halted = 0, state = RUN.
  - The first real instruction is latched on the first rising edge after rst_n rises.
- States:
  - RUN: normal fetch.
  - HALT: PC frozen, IF/ID loads a bubble every cycle, halted = 1. Exits only on reset.
- Per-edge priority in RUN, highest first:
  1. br_ctrl = 1: PC <= br_pc; IF/ID <= bubble. Applied regardless of stall, and j_ctrl and hlt are ignored that cycle, because the decode instruction is younger and squashed.
  2. stall = 1: PC and IF/ID hold. Any j_ctrl or hlt is not acted on; it is re-presented next cycle.
  3. valid & hlt: state <= HALT; PC holds; IF/ID <= bubble.
  4. valid & j_ctrl: PC <= j_pc; IF/ID <= bubble, squashing the sequential instruction fetched this cycle.
  5. Otherwise: instr <= im_data; pc <= PC; valid <= 1; PC <= PC + 1.
- j_ctrl and hlt are qualified by valid; a bubble in decode never redirects or halts.
- PC increment is modulo 2^16; 16'hFFFF wraps to 16'h0000. Targets are used as given, with no alignment checks.
- Latency:
  - im_data is captured into IF/ID on the same edge that advances PC.
  - A redirect target is fetched in the cycle after the redirect edge.
  - Jump penalty is 1 bubble; branch penalty is 2 bubbles (IF/ID flushed here; the decode-stage flush is downstream's job).
- In HALT: stall, j_ctrl, br_ctrl and hlt are ignored. im_addr stays at the PC of the instruction after hlt.
- Reset asserted mid-operation overrides everything immediately; the state machine returns to RUN.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds three 16-bit saturating counters, cleared on reset, each with its own output:
  - fetch_cnt: counts edges taking priority 5.
  - stall_cnt: counts edges taking priority 2.
  - flush_cnt: counts edges taking priority 1 or 4.
- Counters freeze in HALT.
- When undefined, the counters and their ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W and INSTR_W.
  - NOP_INSTR and the opcodes OP_JAL=4'b1101, OP_JR=4'b1110, OP_HLT=4'b1111.
  - The fetch state enum (RUN, HALT).
- One natural sub-module: if_id_reg. It holds the instr/pc/valid register with load, hold and bubble controls, and is reused by the stage-register pattern elsewhere.

Test Plan:
- Reset, then 4 free-running cycles with memory word[n] = 16'h1000+n:
  - im_addr steps 0,1,2,3.
  - instr/pc show 1000/0, 1001/1, 1002/2; valid = 1 from the first edge.
- Jump: decode presents j_ctrl=1, j_pc=16'h0040 while PC = 5:
  - Next edge: valid = 0 and im_addr = 0040.
  - Following edge: pc = 0040.
- Branch with simultaneous stall and j_ctrl: br_ctrl=1, br_pc=16'h0100, stall=1, j_ctrl=1 (j_pc=16'h0200):
  - PC becomes 0100 and valid = 0; the jump is discarded.
- Stall 3 cycles at PC = 7:
  - im_addr stays 7 and instr/pc/valid hold.
  - On release, fetch resumes at 7.
- Halt: hlt with valid at PC = 9:
  - halted = 1 and valid = 0 from the next edge; im_addr stays 9 for 10 cycles despite j_ctrl/br_ctrl pulses.
  - rst_n pulse restores PC = 0 and halted = 0.
- Wrap: br_pc=16'hFFFF, then 2 free cycles:
  - pc = FFFF, then 0000.
